wb_burst_reader: RTL and testbench
==================================

WB_BURST_READER -- requirements
Module: wb_burst_reader

Interface
REQ-001 SHALL have parameter LEN_W, default 8; width of the burst word count.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4; read-data buffer depth; power of two, at least 2.
REQ-003 SHALL have port clk_i, input, 1; the single clock, all logic rising-edge.
REQ-004 SHALL have port rst_n_i, input, 1; asynchronous active-low reset.
REQ-005 SHALL have port start_i, input, 1; a one-cycle request to begin a burst.
REQ-006 SHALL have port adr_i, input, 32; the burst start byte address, word aligned.
REQ-007 SHALL have port len_i, input, LEN_W; the number of 32-bit words to read.
REQ-008 SHALL have port busy_o, output, 1; high from start acceptance until the done pulse.
REQ-009 SHALL have port done_o, output, 1; a one-cycle burst-complete pulse.
REQ-010 SHALL have port err_o, output, 1; sticky timeout flag, cleared by the next accepted start.
REQ-011 SHALL have port dat_o, output, 32; the read-data stream word.
REQ-012 SHALL have port valid_o, output, 1; high when dat_o holds a word.
REQ-013 SHALL have port ready_i, input, 1; consumer accept; a word transfers when valid_o and ready_i are both high.
REQ-014 SHALL have port bus, if_wb.master, the Wishbone pipelined master port (cyc, stb, we, sel, adr, data out, data in, ack, stall).

Function
REQ-015 SHALL implement states IDLE, REQ, WAIT and DONE.
REQ-016 In IDLE, start_i SHALL latch adr_i and len_i, clear err_o and set busy_o next cycle.
REQ-017 In IDLE, start_i with len_i=0 SHALL go to DONE without asserting cyc.
REQ-018 In IDLE, start_i with len_i nonzero SHALL go to REQ.
REQ-019 start_i SHALL be ignored outside IDLE.
REQ-020 In REQ, cyc and stb SHALL be high, with we=0, sel=4'hf and master data out=0.
REQ-021 A request SHALL count as issued on a cycle where stb=1 and stall=0.
REQ-022 On each issued request, adr SHALL advance by 4, wrapping modulo 2^32.
REQ-023 adr, stb, we and sel SHALL hold stable while stall=1.
REQ-024 stb SHALL be deasserted when outstanding + FIFO count >= FIFO_DEPTH, guaranteeing space for every ack; no ack data is ever dropped.
REQ-025 After the last request issues, the block SHALL move to WAIT with stb=0 and cyc=1.
REQ-026 In WAIT, the cycle in which the outstanding count reaches 0 SHALL move the block to DONE; cyc SHALL be 0 in DONE.
REQ-027 DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-028 busy_o SHALL drop in the same cycle the block enters IDLE.
REQ-029 Each ack SHALL push bus data-in into the FIFO in the same cycle.
REQ-030 The FIFO SHALL deliver words in address order.
REQ-031 dat_o and valid_o SHALL come directly from the FIFO head, with one-cycle latency from ack to valid_o.
REQ-032 A simultaneous push and pop SHALL keep the FIFO count unchanged.
REQ-033 A simultaneous issue and ack SHALL keep the outstanding count unchanged.
REQ-034 Acks arriving with no outstanding request SHALL be ignored.
REQ-035 The FIFO SHALL be allowed to hold data after DONE; a new burst SHALL be accepted only once the FIFO is empty.

Reset
REQ-036 While rst_n_i=0, the block SHALL force state=IDLE.
REQ-037 While rst_n_i=0, cyc, stb, we, busy_o, done_o, err_o and valid_o SHALL all be 0.
REQ-038 While rst_n_i=0, adr, sel, dat_o and the master data out SHALL all be 0.
REQ-039 While rst_n_i=0, the outstanding count SHALL be 0 and the FIFO SHALL be empty.
REQ-040 A reset mid-burst SHALL drop cyc asynchronously and discard all in-flight data.

Configuration
REQ-041 With WB_BURST_READER_TIMEOUT_EN defined, an 8-bit watchdog SHALL count cycles with cyc=1 and no ack, and clear on each ack.
REQ-042 With WB_BURST_READER_TIMEOUT_EN defined, a watchdog count reaching 255 SHALL set err_o, drop cyc and stb, zero the outstanding count, and go to DONE; FIFO contents SHALL be kept.
REQ-043 Without WB_BURST_READER_TIMEOUT_EN, no watchdog SHALL exist, err_o SHALL be tied 0, and the block SHALL wait for acks indefinitely.

Verification
REQ-044 Zero-wait test: adr_i=0x1000, len_i=4, stall=0, ack one cycle after each request, ready_i=1 -> adr 0x1000/0x1004/0x1008/0x100C; four words in order; done_o pulses once; cyc low in DONE.
REQ-045 Stall test: stall=1 for 3 cycles on the second request -> adr holds at 0x1004 across the stall; no duplicate or missing issue.
REQ-046 Backpressure test: len_i=8, ready_i=0 -> at most 4 requests outstanding or buffered; stb low; resumes when ready_i=1; 8 words delivered.
REQ-047 Boundary test: len_i=0 -> done_o one cycle after start, cyc never high.
REQ-048 Boundary test: adr_i=0xFFFFFFFC, len_i=2 -> second adr is 0x00000000.
REQ-049 Reset test: rst_n_i low mid-burst -> cyc, stb and valid_o go 0 immediately; after release, a fresh burst completes correctly.
REQ-050 Timeout test (TIMEOUT_EN only): ack never asserted -> err_o=1 and done_o after 255 cycles; err_o clears on the next start.

Source files
------------

// File: rtl/wb_burst_reader_if.sv
// Wishbone pipelined bus bundle shared by the burst reader and its slave.
// Master drives the request side; the slave returns data, ack and stall.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        stall;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack, stall
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack, stall
  );
endinterface

// File: rtl/wb_burst_reader.sv
// Wishbone pipelined burst reader streaming words through a small FIFO.
// Define WB_BURST_READER_TIMEOUT_EN to add the 8-bit ack watchdog.
module wb_burst_reader #(
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [31:0]      adr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      dat_o,
  output logic             valid_o,
  input  logic             ready_i,
  if_wb.master             bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_adr;
  logic [LEN_W-1:0] r_left;
  logic [CW-1:0]    r_out;
  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [31:0]      r_mem [FIFO_DEPTH];

  logic          w_start;
  logic          w_cyc;
  logic          w_stb;
  logic          w_issue;
  logic          w_ack;
  logic          w_pop;
  logic          w_last;
  logic          w_tmo;
  logic [CW:0]   w_load;

  assign w_start = (r_state == IDLE) && start_i && (r_cnt == '0);
  assign w_cyc   = (r_state == REQ) || (r_state == WAIT);
  // Every issued request must have a FIFO slot reserved for its ack.
  assign w_load  = {1'b0, r_out} + {1'b0, r_cnt};
  assign w_stb   = (r_state == REQ) &&
                   (w_load < (CW+1)'(FIFO_DEPTH));
  assign w_issue = w_stb && !bus.stall;
  assign w_ack   = bus.ack && (r_out != '0);
  assign w_pop   = valid_o && ready_i;
  assign w_last  = (r_left == LEN_W'(1));

`ifdef WB_BURST_READER_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       r_err;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (!w_cyc || w_ack)
        r_wdog <= '0;
      else if (r_wdog != 8'hff)
        r_wdog <= r_wdog + 8'd1;
      if (w_start)
        r_err <= 1'b0;
      else if (w_tmo)
        r_err <= 1'b1;
    end
  end

  assign w_tmo = w_cyc && (r_wdog == 8'hff);
  assign err_o = r_err;
`else
  assign w_tmo = 1'b0;
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_start)
          w_next = (len_i == '0) ? DONE : REQ;
      end
      REQ: begin
        if (w_tmo)
          w_next = DONE;
        else if (w_issue && w_last)
          w_next = WAIT;
      end
      WAIT: begin
        if (w_tmo)
          w_next = DONE;
        else if (r_out == '0)
          w_next = DONE;
        else if (r_out == CW'(1) && w_ack)
          w_next = DONE;
      end
      DONE: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_adr  <= '0;
      r_left <= '0;
      r_out  <= '0;
    end else begin
      if (w_start) begin
        r_adr  <= adr_i;
        r_left <= len_i;
      end else if (w_issue) begin
        r_adr  <= r_adr + 32'd4;
        r_left <= r_left - LEN_W'(1);
      end
      if (w_tmo)
        r_out <= '0;
      else if (w_issue && !w_ack)
        r_out <= r_out + CW'(1);
      else if (!w_issue && w_ack)
        r_out <= r_out - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_ack)
        r_wp <= r_wp + AW'(1);
      if (w_pop)
        r_rp <= r_rp + AW'(1);
      if (w_ack && !w_pop)
        r_cnt <= r_cnt + CW'(1);
      else if (!w_ack && w_pop)
        r_cnt <= r_cnt - CW'(1);
    end
  end

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (w_ack)
      r_mem[r_wp] <= bus.dat_r;
  end

  assign valid_o = (r_cnt != '0);
  assign dat_o   = valid_o ? r_mem[r_rp] : 32'h0;
  assign busy_o  = (r_state != IDLE);
  assign done_o  = (r_state == DONE);

  assign bus.cyc   = w_cyc;
  assign bus.stb   = w_stb;
  assign bus.we    = 1'b0;
  assign bus.sel   = w_cyc ? 4'hf : 4'h0;
  assign bus.adr   = r_adr;
  assign bus.dat_w = 32'h0;
endmodule

// File: tb/tb_wb_burst_reader.sv
// Self-checking bench for wb_burst_reader with a randomized Wishbone slave.
// The reference tracks issued/acked/popped word counts per burst.
module tb_wb_burst_reader;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] a;
    int          due;
  } pend_t;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [31:0] adr_in;
  logic [7:0]  len_in;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] dat_o;
  logic        valid_o;
  logic        ready_i;

  if_wb bus ();

  wb_burst_reader #(.LEN_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .start_i (start_i),
    .adr_i   (adr_in),
    .len_i   (len_in),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o),
    .dat_o   (dat_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .bus     (bus.master)
  );

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int issued = 0;
  int acked = 0;
  int popped = 0;
  int exp_len = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int st_cyc = 0;
  int stall_pct = 0;
  int ready_pct = 100;
  int dly_max = 0;
  int scr_left = 0;
  int last_due = 0;
  bit mbusy = 0;
  bit m_err = 0;
  bit tmo_mode = 0;
  bit noack = 0;
  bit spur = 0;
  bit cyc_seen = 0;
  logic [31:0] exp_base = '0;
  pend_t pend[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit st);
    bit accept;
    int d;
    @(negedge clk);
    cyc_n++;
    chk("busy", busy_o, mbusy);
    chk("valid", valid_o, acked != popped);
    chk("stb", bus.stb, bus.cyc && issued < exp_len &&
        (issued - popped) < DEPTH);
    if (bus.cyc) cyc_seen = 1;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc_n;
      chk("cyc_in_done", bus.cyc, 0);
      if (tmo_mode) m_err = 1;
      else chk("issued_at_done", issued, exp_len);
    end
    chk("err", err_o, m_err);
    accept = st && !mbusy && (acked == popped);
    if (done_o) mbusy = 0;
    start_i = st;
    if (!noack && pend.size() != 0 && pend[0].due <= cyc_n) begin
      bus.ack = 1'b1;
      bus.dat_r = word(pend[0].a);
      void'(pend.pop_front());
      acked++;
    end else begin
      bus.ack = spur && pend.size() == 0 && ($urandom_range(0, 3) == 0);
      bus.dat_r = $urandom;
    end
    if (scr_left > 0 && issued == 1 && bus.stb) begin
      bus.stall = 1'b1;
      scr_left--;
    end else begin
      bus.stall = ($urandom_range(0, 99) < stall_pct);
    end
    ready_i = ($urandom_range(0, 99) < ready_pct);
    if (bus.stb) begin
      chk("adr", bus.adr, exp_base + 32'(4 * issued));
      chk("sel", bus.sel, 4'hf);
      chk("we", bus.we, 0);
      if (!bus.stall) begin
        d = cyc_n + 1 + int'($urandom_range(0, dly_max));
        if (d < last_due) d = last_due;
        last_due = d;
        pend.push_back('{a: exp_base + 32'(4 * issued), due: d});
        issued++;
      end
    end
    if (valid_o && ready_i) begin
      chk("dat", dat_o, word(exp_base + 32'(4 * popped)));
      popped++;
    end
    if (accept) begin
      mbusy = 1;
      exp_base = adr_in;
      exp_len = int'(len_in);
      issued = 0;
      acked = 0;
      popped = 0;
      cyc_seen = 0;
      done_cnt = 0;
      m_err = 0;
      st_cyc = cyc_n;
    end
  endtask

  task automatic start_burst(input logic [31:0] a, input int len);
    adr_in = a;
    len_in = 8'(len);
    step(1);
  endtask

  task automatic finish_burst(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      step(0);
      n++;
    end
    chk("done_seen", done_cnt != 0, 1);
    ready_pct = 100;
    n = 0;
    while (acked != popped && n < budget) begin
      step(0);
      n++;
    end
    chk("drained", popped, tmo_mode ? 0 : exp_len);
    step(0);
    step(0);
    chk("done_once", done_cnt, 1);
    chk("cyc_seen", cyc_seen, exp_len != 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start_i = 1'b0;
    adr_in = '0;
    len_in = '0;
    ready_i = 1'b1;
    bus.ack = 1'b0;
    bus.stall = 1'b0;
    bus.dat_r = '0;
    repeat (2) @(negedge clk);
    chk("rst_cyc", bus.cyc, 0);
    chk("rst_stb", bus.stb, 0);
    chk("rst_adr", bus.adr, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_datw", bus.dat_w, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_dat", dat_o, 0);
    rst_n = 1'b1;
    step(0);

    // zero-wait burst
    stall_pct = 0; ready_pct = 100; dly_max = 0; spur = 0;
    start_burst(32'h1000, 4);
    finish_burst(200);

    // three stall cycles on the second request
    scr_left = 3;
    start_burst(32'h1000, 4);
    finish_burst(200);
    chk("stall_used", scr_left, 0);

    // consumer backpressure fills the window
    ready_pct = 0;
    start_burst(32'h2000, 8);
    repeat (20) step(0);
    chk("bp_issued", issued, DEPTH);
    chk("bp_valid", valid_o, 1);
    ready_pct = 100;
    finish_burst(300);

    // empty burst
    start_burst(32'h3000, 0);
    step(0);
    chk("len0_lat", done_cyc - st_cyc, 1);
    finish_burst(50);

    // address wrap
    start_burst(32'hFFFF_FFFC, 2);
    finish_burst(100);

    // data kept after done; start refused until drained
    ready_pct = 0;
    start_burst(32'h6000, 3);
    while (done_cnt == 0 && cyc_n < 5000) step(0);
    step(1);
    step(0);
    chk("start_ignored", busy_o, 0);
    chk("held_data", valid_o, 1);
    finish_burst(100);

    // reset in the middle of a burst
    ready_pct = 0;
    start_burst(32'h7000, 8);
    repeat (6) step(0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_cyc", bus.cyc, 0);
    chk("mid_stb", bus.stb, 0);
    chk("mid_valid", valid_o, 0);
    chk("mid_busy", busy_o, 0);
    chk("mid_adr", bus.adr, 0);
    chk("mid_dat", dat_o, 0);
    bus.ack = 1'b0;
    pend.delete();
    issued = 0; acked = 0; popped = 0; exp_len = 0;
    mbusy = 0; done_cnt = 0; last_due = 0;
    step(0);
    #2 rst_n = 1'b1;
    step(0);
    ready_pct = 100;
    start_burst(32'h8000, 5);
    finish_burst(200);

    // randomized bursts
    spur = 1;
    for (int i = 0; i < 16; i++) begin
      stall_pct = int'($urandom_range(0, 50));
      ready_pct = int'($urandom_range(20, 100));
      dly_max = int'($urandom_range(0, 3));
      start_burst({$urandom} & 32'hFFFF_FFFC, int'($urandom_range(1, 12)));
      finish_burst(2000);
    end
    spur = 0;

`ifdef WB_BURST_READER_TIMEOUT_EN
    stall_pct = 0; ready_pct = 100; dly_max = 0;
    tmo_mode = 1;
    noack = 1;
    start_burst(32'h4000, 6);
    finish_burst(400);
    chk("tmo_lat", (done_cyc - st_cyc) inside {[255:258]}, 1);
    chk("tmo_err", err_o, 1);
    pend.delete();
    tmo_mode = 0;
    noack = 0;
    start_burst(32'h5000, 2);
    step(0);
    chk("err_clr", err_o, 0);
    finish_burst(200);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
